// File: rtl/vmem_fill_engine_if.sv
// Bus bundle for vmem_fill_engine: CPU config port, CPU direct pixel port,
// vmem write port and engine status.
//   cfg_*      : register write strobe/index/data and registered read data
//   cpu_vmem_* : CPU direct pixel write (always has priority at vmem)
//   vmem_*     : merged write port toward the frame buffer
//   busy_o     : engine running
interface vmem_fill_engine_if;
    logic        cfg_we_i;
    logic [1:0]  cfg_addr_i;
    logic [31:0] cfg_wdata_i;
    logic [31:0] cfg_rdata_o;
    logic        cpu_vmem_we_i;
    logic [15:0] cpu_vmem_addr_i;
    logic [2:0]  cpu_vmem_wdata_i;
    logic        vmem_we_o;
    logic [15:0] vmem_addr_o;
    logic [2:0]  vmem_wdata_o;
    logic        busy_o;

    // CPU / bus side
    modport master (
        output cfg_we_i, cfg_addr_i, cfg_wdata_i,
        output cpu_vmem_we_i, cpu_vmem_addr_i, cpu_vmem_wdata_i,
        input  cfg_rdata_o, vmem_we_o, vmem_addr_o, vmem_wdata_o, busy_o
    );

    // Engine side
    modport slave (
        input  cfg_we_i, cfg_addr_i, cfg_wdata_i,
        input  cpu_vmem_we_i, cpu_vmem_addr_i, cpu_vmem_wdata_i,
        output cfg_rdata_o, vmem_we_o, vmem_addr_o, vmem_wdata_o, busy_o
    );
endinterface

// File: rtl/vmem_fill_engine.sv
// Rectangle-fill accelerator in front of the vmem frame buffer.
// The CPU programs two corners (P0/P1) and a colour, then writes start; the
// engine emits one pixel write per free cycle in raster order at {y,x}.
// CPU direct pixel writes always win the vmem port and stall the engine.
// Ports:
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   bus    : vmem_fill_engine_if.slave (config, CPU pixel, vmem, busy)
module vmem_fill_engine #(
    parameter int unsigned SCREEN_W = 240,
    parameter int unsigned SCREEN_H = 240
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    vmem_fill_engine_if.slave      bus
);

    localparam int unsigned COORD_W = 8;
    localparam int unsigned COLOR_W = 3;
    localparam int unsigned POINT_W = 16;
    localparam int unsigned DATA_W  = 32;

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(SCREEN_H - 1);

    localparam logic [1:0] REG_P0    = 2'd0;
    localparam logic [1:0] REG_P1    = 2'd1;
    localparam logic [1:0] REG_COLOR = 2'd2;
    localparam logic [1:0] REG_CTRL  = 2'd3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [POINT_W-1:0]   r_p0;
    logic [POINT_W-1:0]   r_p1;
    logic [COLOR_W-1:0]   r_color;
    logic [COLOR_W-1:0]   r_fill_color;
    logic [COORD_W-1:0]   r_xs;
    logic [COORD_W-1:0]   r_xe;
    logic [COORD_W-1:0]   r_ye;
    logic [COORD_W-1:0]   r_cx;
    logic [COORD_W-1:0]   r_cy;
    logic                 r_done;
    logic [DATA_W-1:0]    r_rdata;

    logic                 w_ctrl_we;
    logic                 w_start;
    logic                 w_clr_done;
    logic                 w_abort;
    logic [COORD_W-1:0]   w_x0;
    logic [COORD_W-1:0]   w_y0;
    logic [COORD_W-1:0]   w_x1;
    logic [COORD_W-1:0]   w_y1;
    logic                 w_issue;
    logic                 w_last;
    logic [DATA_W-1:0]    w_rdata_next;
    logic                 w_unused;

    // Clamp a coordinate to the visible range
    function automatic logic [COORD_W-1:0] clamp(
        input logic [COORD_W-1:0] v,
        input logic [COORD_W-1:0] vmax
    );
        return (v > vmax) ? vmax : v;
    endfunction

    // Control strobes from a CTRL write
    assign w_ctrl_we  = bus.cfg_we_i && (bus.cfg_addr_i == REG_CTRL);
    assign w_start    = w_ctrl_we && bus.cfg_wdata_i[0];
    assign w_clr_done = w_ctrl_we && bus.cfg_wdata_i[1];
    assign w_abort    = w_ctrl_we && bus.cfg_wdata_i[2];

    // Clamped corners; clamping happens before min/max ordering
    assign w_x0 = clamp(r_p0[7:0],  X_MAX);
    assign w_y0 = clamp(r_p0[15:8], Y_MAX);
    assign w_x1 = clamp(r_p1[7:0],  X_MAX);
    assign w_y1 = clamp(r_p1[15:8], Y_MAX);

    // Engine owns the vmem port only when running and the CPU is idle
    assign w_issue = (r_state == S_RUN) && !bus.cpu_vmem_we_i;
    assign w_last  = (r_cx == r_xe) && (r_cy == r_ye);

    // Upper write-data bits have no register behind them
    assign w_unused = ^bus.cfg_wdata_i[31:16];

    // Register read mux, captured one cycle later
    always_comb begin
        w_rdata_next = '0;
        case (bus.cfg_addr_i)
            REG_P0:    w_rdata_next = DATA_W'(r_p0);
            REG_P1:    w_rdata_next = DATA_W'(r_p1);
            REG_COLOR: w_rdata_next = DATA_W'(r_color);
            REG_CTRL:  w_rdata_next = {30'd0, r_done, (r_state == S_RUN)};
            default:   w_rdata_next = '0;
        endcase
    end

    // Config registers, fill FSM and scan counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_p0         <= '0;
            r_p1         <= '0;
            r_color      <= '0;
            r_fill_color <= '0;
            r_xs         <= '0;
            r_xe         <= '0;
            r_ye         <= '0;
            r_cx         <= '0;
            r_cy         <= '0;
            r_done       <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_rdata <= w_rdata_next;

            if (bus.cfg_we_i) begin
                case (bus.cfg_addr_i)
                    REG_P0:    r_p0    <= bus.cfg_wdata_i[15:0];
                    REG_P1:    r_p1    <= bus.cfg_wdata_i[15:0];
                    REG_COLOR: r_color <= bus.cfg_wdata_i[2:0];
                    default:   ;
                endcase
            end

            if (w_clr_done) begin
                r_done <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    // Abort in the same write suppresses the start
                    if (w_start && !w_abort) begin
                        r_xs         <= (w_x0 < w_x1) ? w_x0 : w_x1;
                        r_xe         <= (w_x0 < w_x1) ? w_x1 : w_x0;
                        r_ye         <= (w_y0 < w_y1) ? w_y1 : w_y0;
                        r_cx         <= (w_x0 < w_x1) ? w_x0 : w_x1;
                        r_cy         <= (w_y0 < w_y1) ? w_y0 : w_y1;
                        r_fill_color <= r_color;
                        r_done       <= 1'b0;
                        r_state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else if (w_issue) begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end else if (r_cx == r_xe) begin
                            r_cx <= r_xs;
                            r_cy <= r_cy + COORD_W'(1);
                        end else begin
                            r_cx <= r_cx + COORD_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // vmem port: CPU pass-through unless the engine issues a pixel
    always_comb begin
        bus.vmem_we_o    = bus.cpu_vmem_we_i;
        bus.vmem_addr_o  = bus.cpu_vmem_addr_i;
        bus.vmem_wdata_o = bus.cpu_vmem_wdata_i;
        if (w_issue) begin
            bus.vmem_we_o    = 1'b1;
            bus.vmem_addr_o  = {r_cy, r_cx};
            bus.vmem_wdata_o = r_fill_color;
        end
    end

    assign bus.busy_o      = (r_state == S_RUN);
    assign bus.cfg_rdata_o = r_rdata;

endmodule

// File: tb/tb_vmem_fill_engine.sv
// Directed bench for vmem_fill_engine: reset, small fills, corner swap,
// CPU arbitration, clamping, abort and asynchronous reset mid-fill.
module tb_vmem_fill_engine;

    logic clk;
    logic rst_n;
    int   n_err;
    int   n_checks;

    logic [15:0] q_addr[$];
    logic [2:0]  q_data[$];

    vmem_fill_engine_if u_if ();

    vmem_fill_engine #(
        .SCREEN_W (240),
        .SCREEN_H (240)
    ) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge plus a settle delay
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
        u_if.cfg_we_i    = 1'b1;
        u_if.cfg_addr_i  = a;
        u_if.cfg_wdata_i = d;
        step();
        u_if.cfg_we_i    = 1'b0;
        u_if.cfg_addr_i  = 2'd0;
        u_if.cfg_wdata_i = 32'd0;
    endtask

    task automatic cfg_rd(input logic [1:0] a, output logic [31:0] d);
        u_if.cfg_addr_i = a;
        step();
        d = u_if.cfg_rdata_o;
        u_if.cfg_addr_i = 2'd0;
    endtask

    // Record every vmem write while busy, bounded by a cycle budget
    task automatic capture(input int budget);
        int cyc;
        q_addr.delete();
        q_data.delete();
        cyc = 0;
        while (u_if.busy_o && cyc < budget) begin
            if (u_if.vmem_we_o) begin
                q_addr.push_back(u_if.vmem_addr_o);
                q_data.push_back(u_if.vmem_wdata_o);
            end
            step();
            cyc++;
        end
        chk("capture_done_in_budget", 32'(u_if.busy_o), 32'd0);
    endtask

    logic [15:0] e3_addr [6] = '{16'h0000, 16'h7777, 16'h7777, 16'h0001, 16'h0100, 16'h0101};
    logic [2:0]  e3_data [6] = '{3'd5, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5};
    logic        e3_cpu  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] e4_addr [4] = '{16'hEEEE, 16'hEEEF, 16'hEFEE, 16'hEFEF};

    initial begin
        logic [31:0] rd;
        int k;
        n_err    = 0;
        n_checks = 0;

        // Reset with the CPU writing: vmem mirrors the CPU port
        rst_n                 = 1'b0;
        u_if.cfg_we_i         = 1'b0;
        u_if.cfg_addr_i       = 2'd0;
        u_if.cfg_wdata_i      = 32'd0;
        u_if.cpu_vmem_we_i    = 1'b1;
        u_if.cpu_vmem_addr_i  = 16'h1234;
        u_if.cpu_vmem_wdata_i = 3'd6;
        #1;
        chk("rst_busy", 32'(u_if.busy_o), 32'd0);
        chk("rst_rdata", u_if.cfg_rdata_o, 32'd0);
        chk("rst_mirror_we", 32'(u_if.vmem_we_o), 32'd1);
        chk("rst_mirror_addr", 32'(u_if.vmem_addr_o), 32'h1234);
        chk("rst_mirror_data", 32'(u_if.vmem_wdata_o), 32'd6);
        u_if.cpu_vmem_we_i = 1'b0;
        #1;
        chk("rst_we_idle", 32'(u_if.vmem_we_o), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // 2x2 fill at origin
        cfg_wr(2'd1, 32'h0101);
        cfg_wr(2'd2, 32'd5);
        cfg_wr(2'd3, 32'd1);
        chk("t1_busy", 32'(u_if.busy_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] ea;
            ea = {8'(i / 2), 8'(i % 2)};
            chk($sformatf("t1_we%0d", i), 32'(u_if.vmem_we_o), 32'd1);
            chk($sformatf("t1_addr%0d", i), 32'(u_if.vmem_addr_o), 32'(ea));
            chk($sformatf("t1_data%0d", i), 32'(u_if.vmem_wdata_o), 32'd5);
            step();
        end
        chk("t1_idle_busy", 32'(u_if.busy_o), 32'd0);
        chk("t1_idle_we", 32'(u_if.vmem_we_o), 32'd0);
        cfg_rd(2'd3, rd);
        chk("t1_stat_done", rd, 32'h2);
        cfg_wr(2'd3, 32'h2);
        cfg_rd(2'd3, rd);
        chk("t1_stat_cleared", rd, 32'h0);

        // Same fill with CPU writes in cycles 2 and 3
        u_if.cpu_vmem_addr_i  = 16'h7777;
        u_if.cpu_vmem_wdata_i = 3'd2;
        cfg_wr(2'd3, 32'd1);
        for (int i = 0; i < 6; i++) begin
            u_if.cpu_vmem_we_i = e3_cpu[i];
            #1;
            chk($sformatf("t3_we%0d", i), 32'(u_if.vmem_we_o), 32'd1);
            chk($sformatf("t3_addr%0d", i), 32'(u_if.vmem_addr_o), 32'(e3_addr[i]));
            chk($sformatf("t3_data%0d", i), 32'(u_if.vmem_wdata_o), 32'(e3_data[i]));
            step();
        end
        u_if.cpu_vmem_we_i = 1'b0;
        chk("t3_done_busy", 32'(u_if.busy_o), 32'd0);
        cfg_rd(2'd3, rd);
        chk("t3_stat", rd, 32'h2);

        // Swapped corners: x 10..20, y 5..10
        cfg_wr(2'd0, 32'h0A14);
        cfg_wr(2'd1, 32'h050A);
        cfg_wr(2'd2, 32'd6);
        cfg_wr(2'd3, 32'd1);
        capture(200);
        chk("t2_count", 32'(q_addr.size()), 32'd66);
        k = 0;
        for (int y = 5; y <= 10; y++) begin
            for (int x = 10; x <= 20; x++) begin
                chk($sformatf("t2_addr%0d", k), 32'(q_addr[k]), 32'({8'(y), 8'(x)}));
                k++;
            end
        end
        chk("t2_data_first", 32'(q_data[0]), 32'd6);
        chk("t2_data_last", 32'(q_data[65]), 32'd6);
        cfg_rd(2'd0, rd);
        chk("t2_rd_p0", rd, 32'h0A14);
        cfg_rd(2'd2, rd);
        chk("t2_rd_color", rd, 32'd6);

        // Out-of-range corners clamp to 238..239
        cfg_wr(2'd0, 32'hEEEE);
        cfg_wr(2'd1, 32'hFFFF);
        cfg_wr(2'd3, 32'd1);
        capture(20);
        chk("t4_count", 32'(q_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_addr%0d", i), 32'(q_addr[i]), 32'(e4_addr[i]));
        end

        // Full-screen fill aborted after 100 pixels; start in the same write ignored
        cfg_wr(2'd0, 32'h0000);
        cfg_wr(2'd2, 32'd3);
        cfg_wr(2'd3, 32'd1);
        for (int i = 0; i < 100; i++) step();
        chk("t5_addr100", 32'(u_if.vmem_addr_o), 32'h0064);
        chk("t5_data100", 32'(u_if.vmem_wdata_o), 32'd3);
        cfg_wr(2'd3, 32'h5);
        chk("t5_busy", 32'(u_if.busy_o), 32'd0);
        chk("t5_we", 32'(u_if.vmem_we_o), 32'd0);
        step();
        chk("t5_we_later", 32'(u_if.vmem_we_o), 32'd0);
        cfg_rd(2'd3, rd);
        chk("t5_stat", rd, 32'h0);

        // Async reset mid-fill, between clock edges
        cfg_wr(2'd3, 32'd1);
        step();
        step();
        chk("t6_running", 32'(u_if.busy_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(u_if.busy_o), 32'd0);
        chk("t6_rst_we", 32'(u_if.vmem_we_o), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t6_no_write%0d", i), 32'(u_if.vmem_we_o), 32'd0);
        end
        cfg_rd(2'd3, rd);
        chk("t6_stat", rd, 32'h0);
        cfg_rd(2'd1, rd);
        chk("t6_p1_cleared", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/vmem_fill_engine.md
Name: vmem_fill_engine

Overview:
- Memory-mapped rectangle-fill accelerator that sits directly upstream of the vmem frame buffer, between the CPU data bus and the vmem write port.
- The CPU programs two corners and a 3-bit colour, then starts the engine.
- The engine emits one vmem pixel write per cycle in raster order (y outer, x inner) at vmem address {y[7:0], x[7:0]}.
- CPU direct pixel writes always take priority and pass straight through to vmem.

Parameters:
- SCREEN_W, 240, visible width; x coordinates are clamped to SCREEN_W-1.
- SCREEN_H, 240, visible height; y coordinates are clamped to SCREEN_H-1.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  reset, asynchronous, active-low
- cfg_we_i  input  1  register write strobe (CPU store decoded to this block)
- cfg_addr_i  input  2  register index (dbus_addr[3:2])
- cfg_wdata_i  input  32  register write data
- cfg_rdata_o  output  32  register read data, registered, 1-cycle latency
- cpu_vmem_we_i  input  1  CPU direct vmem write strobe
- cpu_vmem_addr_i  input  16  CPU direct vmem address
- cpu_vmem_wdata_i  input  3  CPU direct pixel {R,G,B}
- vmem_we_o  output  1  write strobe to vmem
- vmem_addr_o  output  16  vmem address
- vmem_wdata_o  output  3  vmem pixel
- busy_o  output  1  engine running

Behaviour:
- Registers:
  - 0 P0: [7:0]=x0, [15:8]=y0.
  - 1 P1: [7:0]=x1, [15:8]=y1.
  - 2 COLOR: [2:0].
  - 3 CTRL/STAT, write side: bit0=start, bit1=clear done, bit2=abort.
  - 3 CTRL/STAT, read side: {29'b0, 1'b0, done, busy}.
  - Reads of 0–2 return the stored value, zero-extended.
- Reset (async, rst_ni=0):
  - P0, P1 and COLOR are cleared to 0; done=0; state=IDLE.
  - busy_o=0, cfg_rdata_o=0.
  - vmem_we_o follows cpu_vmem_we_i combinationally, so it is 0 unless the CPU is writing.
  - Reset mid-fill stops the fill immediately; no further engine writes occur.
- P0, P1 and COLOR are writable at any time. The engine works only from copies latched at start, so writes during a fill do not affect that fill.
- States: IDLE, RUN.
- IDLE, start=1 written:
  - Latch xs=min(x0,x1), xe=max(x0,x1), ys=min(y0,y1), ye=max(y0,y1), each clamped to SCREEN_W-1 / SCREEN_H-1.
  - Latch the colour. Set cx=xs, cy=ys. Clear done. Go to RUN.
  - busy_o=1 from the next cycle.
- RUN, pixel issue:
  - Each cycle with cpu_vmem_we_i=0, drive vmem_we_o=1, vmem_addr_o={cy,cx}, vmem_wdata_o=colour.
  - Advance: if cx==xe then cx=xs and cy=cy+1, else cx=cx+1.
- RUN, completion:
  - On the write of (xe,ye), the next state is IDLE and done is set in the same edge.
  - Total engine writes = (xe-xs+1)*(ye-ys+1).
  - First pixel is written in the cycle after the start write.
- RUN, arbitration: a cycle with cpu_vmem_we_i=1 outputs the CPU address and data, and the engine holds cx, cy (stall). No engine pixel is dropped or duplicated.
- Start written while RUN: ignored.
- Abort written while RUN: go to IDLE next edge, done is not set, and no further engine writes occur. Abort in IDLE has no effect.
- Start and abort in the same write: abort wins; the engine stays or returns to IDLE.
- Clear done (bit1) clears done. It is also combined with start: start clears done.
- Degenerate case x0==x1, y0==y1: exactly 1 write, then done.
- Coordinates ≥ SCREEN_W/SCREEN_H are clamped before the min/max ordering, e.g. x=250 becomes 239.
- cx and cy are 8 bits and never wrap past xe/ye.
- In IDLE, vmem outputs mirror the CPU inputs.

Test Plan:
- Reset applied with P0=0x0000, P1=0x0101 (x1=1, y1=1), COLOR=5, then start -> next 4 cycles write addr 0x0000, 0x0001, 0x0100, 0x0101 with data 5; done=1, busy=0 afterwards; STAT read returns 0x2.
- P0=0x0A14 (x0=20, y0=10), P1=0x050A (x1=10, y1=5) -> corners swapped; 66 writes from {5,10} to {10,20}, row-major, each address exactly once.
- Same 4-pixel fill with cpu_vmem_we_i=1 (addr 0x7777, data 2) in cycles 2 and 3 after start -> vmem sees the CPU writes in those cycles; the engine finishes at cycle 6 with all 4 pixels intact.
- P1=0xFFFF (x1=255, y1=255) and P0=0xEEEE (x0=238, y0=238) -> clamped to 238..239 in both axes; exactly 4 writes, nothing at x or y ≥ 240.
- Start a 240x240 fill, write abort after 100 pixels -> writes stop within 1 cycle; busy=0, done=0; a second start during the abort cycle is ignored.
- Assert rst_ni low asynchronously mid-fill (between clock edges) -> busy_o=0 and vmem_we_o=0 immediately; after release STAT reads 0 and no engine writes occur.
